// File: rtl/systolic_ctrl.sv
// Sequencer for a 3x3 weight-stationary systolic array: weight-row load, skewed
// activation streaming, drain timing and de-skew of the column partial sums.
//
// state  | meaning
// IDLE   | waiting for start; job parameters latched on start
// WLOAD  | accepting three weight rows onto the array
// STREAM | accepting n_vec activation vectors, bubbles feed zeros
// DRAIN  | flushing the array for ARR_LAT+2 cycles
// DONE   | one-cycle done pulse, start ignored
module systolic_ctrl #(
    parameter int DW      = 13,
    parameter int ARR_LAT = 3,
    parameter int NW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n_vec,
    input  logic          rot_mode,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data0,
    input  logic [DW-1:0] w_data1,
    input  logic [DW-1:0] w_data2,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] a_data0,
    input  logic [DW-1:0] a_data1,
    input  logic [DW-1:0] a_data2,
    output logic          r_valid,
    output logic [DW-1:0] r_data0,
    output logic [DW-1:0] r_data1,
    output logic [DW-1:0] r_data2,
    output logic          busy,
    output logic          done,
    output logic          arr_weight_en,
    output logic          arr_weight_sel,
    output logic [DW-1:0] arr_in0,
    output logic [DW-1:0] arr_in1,
    output logic [DW-1:0] arr_in2,
    output logic [DW-1:0] arr_psum_in0,
    output logic [DW-1:0] arr_psum_in1,
    output logic [DW-1:0] arr_psum_in2,
    input  logic [DW-1:0] arr_psum0,
    input  logic [DW-1:0] arr_psum1,
    input  logic [DW-1:0] arr_psum2
);

    localparam int TL = ARR_LAT + 2;
    localparam int DCW = $clog2(TL) + 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(TL - 1);

    typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          state_q;
    logic [NW-1:0]   n_q, vcnt_q;
    logic [1:0]      wcnt_q;
    logic [DCW-1:0]  dcnt_q;
    logic            rot_q, busy_q, done_q, w_ready_q, a_ready_q;
    logic [DW-1:0]   sk1_q, sk2a_q, sk2b_q, ps0a_q, ps0b_q, ps1_q;
    logic [TL-1:0]   tag_q;
    logic            w_acc, a_acc;

    assign w_acc = w_valid & w_ready_q;
    assign a_acc = a_valid & a_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            vcnt_q    <= '0;
            wcnt_q    <= '0;
            dcnt_q    <= '0;
            rot_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_ready_q <= 1'b0;
            a_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    n_q       <= n_vec;
                    rot_q     <= rot_mode;
                    wcnt_q    <= '0;
                    busy_q    <= 1'b1;
                    w_ready_q <= 1'b1;
                    state_q   <= S_WLOAD;
                end
                S_WLOAD: if (w_acc) begin
                    if (wcnt_q == 2'd2) begin
                        wcnt_q    <= '0;
                        w_ready_q <= 1'b0;
                        vcnt_q    <= '0;
                        dcnt_q    <= DRAIN_LAST;
                        if (n_q != '0) begin
                            a_ready_q <= 1'b1;
                            state_q   <= S_STREAM;
                        end else begin
                            state_q   <= S_DRAIN;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                // Compare before increment so n_vec = all-ones never wraps the counter.
                S_STREAM: if (a_acc) begin
                    if (vcnt_q == n_q - NW'(1)) begin
                        a_ready_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        vcnt_q <= vcnt_q + NW'(1);
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        dcnt_q <= dcnt_q - DCW'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    rot_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Skew/de-skew registers and the result tag line; zeros flow on every non-accept cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sk1_q  <= '0;
            sk2a_q <= '0;
            sk2b_q <= '0;
            ps0a_q <= '0;
            ps0b_q <= '0;
            ps1_q  <= '0;
            tag_q  <= '0;
        end else begin
            sk1_q  <= a_acc ? a_data1 : '0;
            sk2a_q <= a_acc ? a_data2 : '0;
            sk2b_q <= sk2a_q;
            ps0a_q <= arr_psum0;
            ps0b_q <= ps0a_q;
            ps1_q  <= arr_psum1;
            tag_q  <= {tag_q[TL-2:0], a_acc};
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign w_ready        = w_ready_q;
    assign a_ready        = a_ready_q;
    assign arr_weight_sel = rot_q;
    assign arr_weight_en  = w_acc;

    assign arr_in0 = w_acc ? w_data0 : (a_acc ? a_data0 : '0);
    assign arr_in1 = w_acc ? w_data1 : (w_ready_q ? '0 : sk1_q);
    assign arr_in2 = w_acc ? w_data2 : (w_ready_q ? '0 : sk2b_q);

    assign arr_psum_in0 = '0;
    assign arr_psum_in1 = '0;
    assign arr_psum_in2 = '0;

    assign r_valid = tag_q[TL-1];
    assign r_data0 = r_valid ? ps0b_q : '0;
    assign r_data1 = r_valid ? ps1_q : '0;
    assign r_data2 = r_valid ? arr_psum2 : '0;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DW, 13, data width of every data port.
- ARR_LAT, 3, array cycles from arr_in0 to matching arr_psum0.
- NW, 8, width of n_vec.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin job; sampled in IDLE only.
- n_vec, in, NW, activation vector count; latched at start.
- rot_mode, in, 1, weight-recirculate mode; latched at start.
- w_valid / w_ready, in / out, 1 / 1, weight-row handshake.
- w_data0..2, in, DW each, one weight row.
- a_valid / a_ready, in / out, 1 / 1, activation-vector handshake.
- a_data0..2, in, DW each, one activation vector.
- r_valid, out, 1, result vector valid; no back-pressure.
- r_data0..2, out, DW each, de-skewed result vector.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle job-complete pulse.
- arr_weight_en, out, 1, array weight-load enable.
- arr_weight_sel, out, 1, array weight-select.
- arr_in0..2, out, DW each, array element inputs.
- arr_psum_in0..2, out, DW each, array psum inputs; constant 0.
- arr_psum0..2, in, DW each, array column psum outputs.

Function
REQ-003 SHALL implement states IDLE, WLOAD, STREAM, DRAIN, DONE.

REQ-004 IDLE: start=1 SHALL latch n_vec and rot_mode, then go to WLOAD next cycle. start in any other state SHALL be ignored.

REQ-005 WLOAD: w_ready=1. Each w_valid&w_ready cycle:
- drives w_data0..2 onto arr_in0..2 with arr_weight_en=1 in that same cycle;
- increments the weight counter.
A w_valid=0 cycle SHALL drive arr_weight_en=0 and arr_in*=0.

REQ-006 After the 3rd accepted weight row: go to STREAM if latched n_vec>0, else go to DRAIN.

REQ-007 arr_weight_sel SHALL equal latched rot_mode while busy, and 0 in IDLE.

REQ-008 STREAM: a_ready=1. The accepted vector is A = a_data*, or all zero if a_valid=0 (bubble).
- arr_in0 = A0 in the same cycle.
- arr_in1 = A1 delayed 1 cycle.
- arr_in2 = A2 delayed 2 cycles.
- Skew registers SHALL load zero on bubbles.

REQ-009 STREAM SHALL go to DRAIN in the cycle after the n_vec-th accepted vector.

REQ-010 DRAIN: a_ready=0 and arr_weight_en=0; skew registers keep shifting zeros. Exit to DONE after exactly ARR_LAT+2 cycles.

REQ-011 Result de-skew:
- r_data0 = arr_psum0 delayed 2 cycles.
- r_data1 = arr_psum1 delayed 1 cycle.
- r_data2 = arr_psum2 undelayed.

REQ-012 r_valid SHALL equal a accept (a_valid&a_ready) delayed ARR_LAT+2 cycles via a tag shift register. Exactly n_vec r_valid pulses per job, in acceptance order. r_data SHALL be 0 when r_valid=0.

REQ-013 DONE SHALL assert done=1 for one cycle, then go to IDLE. A start in that cycle SHALL be ignored.

REQ-014 w_ready SHALL be 0 outside WLOAD; a_ready SHALL be 0 outside STREAM.

REQ-015 All arithmetic is pass-through. No truncation or extension; every data path is DW bits.

REQ-016 n_vec = 2^NW-1 SHALL complete without counter wrap. The vector counter SHALL be NW bits and compare before increment.

Reset
REQ-017 reset=1 SHALL, on the next clk edge and in any state including mid-job:
- force IDLE;
- clear all counters, skew registers, the de-skew pipeline and the tag shift register;
- drive busy, done, r_valid, w_ready, a_ready, arr_weight_en, arr_weight_sel = 0;
- drive all arr_in*, arr_psum_in*, r_data* = 0.

REQ-018 No result from a job aborted by reset SHALL appear after reset is released.

Verification
REQ-019 The bench SHALL cover these scenarios (stimulus -> required response):
- Basic job: start, n_vec=2, rot_mode=0; 3 weight rows back-to-back. -> arr_weight_en high exactly 3 cycles; arr_in* equals each w_data row in its accept cycle.
- Skew check: vectors (1,2,3) then (4,5,6). -> arr_in0 = 1,4; arr_in1 = 0,2,5 (1-cycle lag); arr_in2 = 0,0,3,6 (2-cycle lag).
- Bubbles: n_vec=3 with a_valid low for 2 cycles between vectors. -> exactly 3 r_valid pulses, each ARR_LAT+2=5 cycles after its accept; done 5 cycles after the 3rd accept plus 1.
- n_vec=0: -> WLOAD, then DRAIN for 5 cycles, then done; zero r_valid pulses; a_ready never high.
- Reset mid-STREAM after 1 of 4 vectors. -> next cycle busy=0, all outputs 0; no r_valid afterward; a new start runs normally.
- Stall and busy start: w_valid low 3 cycles during WLOAD, plus start pulsed while busy. -> no extra weight loads, arr_weight_sel = rot_mode throughout, second start ignored.
